// File: rtl/ahb_oor_pkg.sv
// Shared encodings for the AHB out-of-range guard.
// HTRANS/HRESP codes and the default-slave response state type.
package ahb_oor_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ERR1 = 2'b01,
    ERR2 = 2'b10
  } oor_state_t;

endpackage

// File: rtl/ahb_oor_guard_region_match.sv
// Single address-window comparator, base..base+~mask.
// The top bound saturates at all-ones instead of wrapping.
module oor_region_match #(
  parameter int              W    = 32,
  parameter logic [W-1:0]    BASE = '0,
  parameter logic [W-1:0]    MASK = '1
) (
  input  logic [W-1:0] addr_i,
  input  logic         en_i,
  output logic         hit_o
);

  localparam logic [W:0]   SUM  = {1'b0, BASE} + {1'b0, ~MASK};
  localparam logic [W-1:0] TOP  = SUM[W] ? {W{1'b1}} : SUM[W-1:0];
  localparam logic [W:0]   SPAN = {1'b0, TOP - BASE};

  logic [W:0] off;

  // An address below BASE borrows into bit W and so exceeds SPAN.
  assign off   = {1'b0, addr_i} - {1'b0, BASE};
  assign hit_o = en_i && (off <= SPAN);

endmodule

// File: rtl/ahb_oor_guard.sv
// AHB-Lite address guard: window decode plus an ERROR default slave
// with fault capture, saturating error count and sticky interrupt.
module ahb_oor_guard
  import ahb_oor_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGIONS = 6,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
    {NUM_REGIONS{{ADDR_WIDTH{1'b0}}}},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK =
    {NUM_REGIONS{{{(ADDR_WIDTH-12){1'b1}}, 12'h000}}},
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ADDR_WIDTH-1:0]  haddr_i,
  input  logic [1:0]             htrans_i,
  input  logic                   hwrite_i,
  input  logic                   hsel_i,
  input  logic                   hready_i,
  output logic [NUM_REGIONS-1:0] region_hit_o,
  output logic                   valid_o,
  output logic                   hreadyout_o,
  output logic                   hresp_o,
  output logic [ADDR_WIDTH-1:0]  err_addr_o,
  output logic                   err_write_o,
  output logic [CNT_WIDTH-1:0]   err_cnt_o,
  output logic                   irq_o,
  input  logic                   irq_clr_i
);

  for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
    oor_region_match #(
      .W    (ADDR_WIDTH),
      .BASE (REGION_BASE[r*ADDR_WIDTH +: ADDR_WIDTH]),
      .MASK (REGION_MASK[r*ADDR_WIDTH +: ADDR_WIDTH])
    ) u_match (
      .addr_i (haddr_i),
      .en_i   (hsel_i),
      .hit_o  (region_hit_o[r])
    );
  end

  assign valid_o = |region_hit_o;

  oor_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   irq_q, irq_d;
  logic                   active;
  logic                   fault;
  logic                   accept;

  assign active = (htrans_i == HTRANS_NONSEQ) ||
                  (htrans_i == HTRANS_SEQ);
  assign fault  = hsel_i && hready_i && active && !valid_o;
  // ERR1 holds HREADY low, so only IDLE and ERR2 can take a new fault.
  assign accept = fault && (state_q != ERR1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ERR1;
      ERR1:    state_d = ERR2;
      ERR2:    state_d = accept ? ERR1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    irq_d  = irq_q;
    if (irq_clr_i) irq_d = 1'b0;
    if (accept) begin
      addr_d = haddr_i;
      wr_d   = hwrite_i;
      irq_d  = 1'b1;
      if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    unique case (state_q)
      ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
      end
      ERR2:    hresp_o = HRESP_ERROR;
      default: hresp_o = HRESP_OKAY;
    endcase
  end

  assign err_addr_o  = addr_q;
  assign err_write_o = wr_q;
  assign err_cnt_o   = cnt_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_ahb_oor_guard.sv
// Directed bench for ahb_oor_guard: decode, error response,
// capture, saturation, interrupt and reset-during-error.
module tb_ahb_oor_guard;

  localparam int AW = 32;
  localparam int NR = 4;
  localparam int CW = 2;

  localparam logic [NR*AW-1:0] BASES = {
    32'hFFFF_F000, 32'h2000_0800, 32'h2000_0000, 32'h0000_0000};
  localparam logic [NR*AW-1:0] MASKS = {
    32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic          hsel;
  logic          hready;
  logic          irq_clr;
  logic [NR-1:0] hit;
  logic          valid;
  logic          hreadyout;
  logic          hresp;
  logic [AW-1:0] err_addr;
  logic          err_write;
  logic [CW-1:0] err_cnt;
  logic          irq;

  int total = 0;
  int fails = 0;

  ahb_oor_guard #(
    .ADDR_WIDTH  (AW),
    .NUM_REGIONS (NR),
    .REGION_BASE (BASES),
    .REGION_MASK (MASKS),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .haddr_i      (haddr),
    .htrans_i     (htrans),
    .hwrite_i     (hwrite),
    .hsel_i       (hsel),
    .hready_i     (hready),
    .region_hit_o (hit),
    .valid_o      (valid),
    .hreadyout_o  (hreadyout),
    .hresp_o      (hresp),
    .err_addr_o   (err_addr),
    .err_write_o  (err_write),
    .err_cnt_o    (err_cnt),
    .irq_o        (irq),
    .irq_clr_i    (irq_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic [1:0] t,
                       input logic [31:0] a, input logic w);
    hsel   = s;
    hready = r;
    htrans = t;
    haddr  = a;
    hwrite = w;
    #1;
  endtask

  task automatic resp(input string tag, input logic rdy,
                      input logic rsp);
    chk({tag, "_hreadyout"}, 32'(hreadyout), 32'(rdy));
    chk({tag, "_hresp"}, 32'(hresp), 32'(rsp));
  endtask

  initial begin
    rst     = 1'b1;
    irq_clr = 1'b0;
    drive(1'b0, 1'b1, 2'b00, 32'h0, 1'b0);
    tick();
    rst = 1'b0;
    resp("rst", 1'b1, 1'b0);
    chk("rst_addr", err_addr, 32'h0);
    chk("rst_write", 32'(err_write), 32'h0);
    chk("rst_cnt", 32'(err_cnt), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // in-range NONSEQ at the top of region 0
    drive(1'b1, 1'b1, 2'b10, 32'h0000_FFFC, 1'b0);
    chk("ok_hit", 32'(hit), 32'h1);
    chk("ok_valid", 32'(valid), 32'h1);
    tick();
    resp("ok", 1'b1, 1'b0);
    chk("ok_cnt", 32'(err_cnt), 32'h0);

    // just past the top of region 0 -> error
    drive(1'b1, 1'b1, 2'b10, 32'h0001_0000, 1'b1);
    chk("past_hit", 32'(hit), 32'h0);
    chk("past_valid", 32'(valid), 32'h0);
    tick();
    resp("e1_err1", 1'b0, 1'b1);
    chk("e1_addr", err_addr, 32'h0001_0000);
    chk("e1_write", 32'(err_write), 32'h1);
    chk("e1_cnt", 32'(err_cnt), 32'h1);
    chk("e1_irq", 32'(irq), 32'h1);
    drive(1'b1, 1'b0, 2'b10, 32'h0001_0000, 1'b1);
    tick();
    resp("e1_err2", 1'b1, 1'b1);
    drive(1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    tick();
    resp("e1_idle", 1'b1, 1'b0);
    chk("e1_cnt_hold", 32'(err_cnt), 32'h1);

    // back-to-back errors
    drive(1'b1, 1'b1, 2'b11, 32'h3000_0000, 1'b0);
    tick();
    resp("b2b_a_err1", 1'b0, 1'b1);
    chk("b2b_a_cnt", 32'(err_cnt), 32'h2);
    chk("b2b_a_write", 32'(err_write), 32'h0);
    drive(1'b1, 1'b0, 2'b11, 32'h3000_0000, 1'b0);
    tick();
    resp("b2b_a_err2", 1'b1, 1'b1);
    drive(1'b1, 1'b1, 2'b10, 32'h4000_0000, 1'b0);
    tick();
    resp("b2b_b_err1", 1'b0, 1'b1);
    chk("b2b_b_addr", err_addr, 32'h4000_0000);
    chk("b2b_b_cnt", 32'(err_cnt), 32'h3);
    drive(1'b1, 1'b0, 2'b10, 32'h4000_0000, 1'b0);
    tick();
    resp("b2b_b_err2", 1'b1, 1'b1);
    drive(1'b1, 1'b1, 2'b00, 32'h5000_0000, 1'b0);
    tick();
    resp("b2b_idle", 1'b1, 1'b0);

    // IDLE and BUSY to a bad address never fault
    drive(1'b1, 1'b1, 2'b00, 32'h5000_0000, 1'b1);
    tick();
    resp("idle_bad", 1'b1, 1'b0);
    drive(1'b1, 1'b1, 2'b01, 32'h5000_0000, 1'b1);
    tick();
    resp("busy_bad", 1'b1, 1'b0);
    chk("nofault_addr", err_addr, 32'h4000_0000);
    chk("nofault_cnt", 32'(err_cnt), 32'h3);

    // decode: carry-clamped window, overlap, single windows, hsel gate
    drive(1'b1, 1'b1, 2'b00, 32'hFFFF_FFFC, 1'b0);
    chk("carry_hit", 32'(hit), 32'h8);
    drive(1'b1, 1'b1, 2'b00, 32'hFFFF_EFFF, 1'b0);
    chk("carry_below", 32'(hit), 32'h0);
    drive(1'b1, 1'b1, 2'b00, 32'h2000_0900, 1'b0);
    chk("overlap_hit", 32'(hit), 32'h6);
    chk("overlap_valid", 32'(valid), 32'h1);
    drive(1'b1, 1'b1, 2'b00, 32'h2000_0100, 1'b0);
    chk("r1_only", 32'(hit), 32'h2);
    drive(1'b1, 1'b1, 2'b00, 32'h2000_1000, 1'b0);
    chk("r2_only", 32'(hit), 32'h4);
    drive(1'b1, 1'b1, 2'b00, 32'h2000_1800, 1'b0);
    chk("r2_past", 32'(hit), 32'h0);
    drive(1'b0, 1'b1, 2'b10, 32'h2000_0900, 1'b0);
    chk("nosel_hit", 32'(hit), 32'h0);
    chk("nosel_valid", 32'(valid), 32'h0);
    drive(1'b0, 1'b1, 2'b10, 32'h5000_0000, 1'b0);
    tick();
    resp("nosel_bad", 1'b1, 1'b0);

    // interrupt clear, then clear coinciding with a fault
    drive(1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("irq_clr", 32'(irq), 32'h0);
    drive(1'b1, 1'b1, 2'b10, 32'h6000_0000, 1'b1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("irq_setwins", 32'(irq), 32'h1);
    chk("sat4_cnt", 32'(err_cnt), 32'h3);
    drive(1'b1, 1'b0, 2'b10, 32'h6000_0000, 1'b1);
    tick();
    drive(1'b1, 1'b1, 2'b10, 32'h7000_0000, 1'b1);
    tick();
    resp("sat5_err1", 1'b0, 1'b1);
    chk("sat5_cnt", 32'(err_cnt), 32'h3);
    chk("sat5_addr", err_addr, 32'h7000_0000);

    // reset during ERR1 abandons the response
    drive(1'b1, 1'b0, 2'b10, 32'h7000_0000, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resp("rst_err1", 1'b1, 1'b0);
    chk("rst_err1_addr", err_addr, 32'h0);
    chk("rst_err1_write", 32'(err_write), 32'h0);
    chk("rst_err1_cnt", 32'(err_cnt), 32'h0);
    chk("rst_err1_irq", 32'(irq), 32'h0);
    drive(1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    tick();
    resp("post_rst", 1'b1, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
